uart_rx_baud_controller: RTL and testbench

- Sequences UART receive sampling for one serial line.
- Generates the oversample tick from a run-time divide factor, then aligns to the start-bit centre.
- Strobes each data bit and the stop bit at bit centre, and assembles the received byte.
- Sits between the raw rx pin and the receiver datapath.
- Owns the divide configuration: the divide factor changes only between frames.

---
 rtl/uart_rx_baud_controller_if.sv | 26 ++
 rtl/uart_rx_baud_controller.sv | 144 ++++++++++++++
 tb/tb_uart_rx_baud_controller.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_baud_controller_if.sv
// Bundles the configuration, serial input and receive-side strobes of the UART RX baud controller.
interface uart_rx_baud_controller_if #(
    parameter int DATA_BITS = 8
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    logic [31:0]          div_factor;
    logic                 rx_in;
    logic                 tick;
    logic                 sample_strobe;
    logic [IDX_W-1:0]     bit_index;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_error;
    logic                 busy;

    modport master (
        output div_factor, rx_in,
        input  tick, sample_strobe, bit_index, rx_data, rx_valid, frame_error, busy
    );

    modport slave (
        input  div_factor, rx_in,
        output tick, sample_strobe, bit_index, rx_data, rx_valid, frame_error, busy
    );
endinterface

// File: rtl/uart_rx_baud_controller.sv
// UART receive sequencer: oversample tick generation, start-bit centre alignment,
// per-bit centre strobes and byte assembly for a single serial line.
module uart_rx_baud_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                     clk_in,
    input  logic                     reset,
    uart_rx_baud_controller_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_sync, rx_prev;
    logic [31:0]          div_reg, tick_cnt;
    logic [OS_W-1:0]      os_cnt;
    logic [IDX_W-1:0]     bit_index;
    logic [DATA_BITS-1:0] shift_reg, rx_data;
    logic                 busy, tick, fall_edge;
    logic                 sample_strobe, rx_valid, frame_error;
    logic                 start_accept, shift_en;

    assign fall_edge = rx_prev & ~rx_sync;
    // >= rather than == so a tick counter left above a freshly loaded, smaller divisor still wraps.
    assign tick = (div_reg != 32'd0) && (tick_cnt >= div_reg - 32'd1);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rx_in;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            div_reg <= '0;
        end else if (state == IDLE) begin
            div_reg <= (bus.div_factor == 32'd0) ? 32'd1 : bus.div_factor;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset || start_accept || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset || (state_next != state)) begin
            os_cnt <= '0;
        end else if (tick) begin
            os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        sample_strobe = 1'b0;
        rx_valid      = 1'b0;
        frame_error   = 1'b0;
        start_accept  = 1'b0;
        shift_en      = 1'b0;
        case (state)
            IDLE: begin
                if (fall_edge) begin
                    state_next   = START;
                    start_accept = 1'b1;
                end
            end
            START: begin
                if (tick && os_cnt == OS_HALF) begin
                    sample_strobe = 1'b1;
                    state_next    = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && os_cnt == OS_LAST) begin
                    sample_strobe = 1'b1;
                    shift_en      = 1'b1;
                    if (bit_index == IDX_LAST) state_next = STOP;
                end
            end
            STOP: begin
                if (tick && os_cnt == OS_LAST) begin
                    sample_strobe = 1'b1;
                    rx_valid      = 1'b1;
                    frame_error   = ~rx_sync;
                    state_next    = rx_sync ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_sync) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            shift_reg <= '0;
            rx_data   <= '0;
            bit_index <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            if (state == START && state_next == DATA) begin
                bit_index <= '0;
            end else if (shift_en) begin
                bit_index <= bit_index + IDX_W'(1);
            end
            if (shift_en) shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            if (rx_valid) rx_data <= shift_reg;
        end
    end

    assign bus.tick          = tick;
    assign bus.sample_strobe = sample_strobe;
    assign bus.bit_index     = bit_index;
    assign bus.rx_data       = rx_data;
    assign bus.rx_valid      = rx_valid;
    assign bus.frame_error   = frame_error;
    assign bus.busy          = busy;
endmodule

// File: tb/tb_uart_rx_baud_controller.sv
// Self-checking bench for uart_rx_baud_controller: drives serial frames and compares against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_baud_controller;
    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    logic clk_in = 1'b0;
    logic reset  = 1'b0;

    uart_rx_baud_controller_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx_baud_controller #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk_in(clk_in),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int fall_cyc = 0;

    // Event recorder: cycle stamps of strobes/valids, captured bytes, tick count.
    int                   strobe_q[$];
    int                   valid_q[$];
    logic                 ferr_q[$];
    logic [DATA_BITS-1:0] data_q[$];
    int                   n_tick = 0;
    int                   stray_ferr = 0;
    logic                 valid_d = 1'b0;

    always @(negedge clk_in) begin
        if (bus.sample_strobe === 1'b1) strobe_q.push_back(cyc);
        if (bus.rx_valid === 1'b1) begin
            valid_q.push_back(cyc);
            ferr_q.push_back(bus.frame_error);
        end else if (bus.frame_error === 1'b1) begin
            stray_ferr++;
        end
        if (valid_d) data_q.push_back(bus.rx_data);
        valid_d = (bus.rx_valid === 1'b1);
        if (bus.tick === 1'b1) n_tick++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_lat(input int div);
        int d;
        d = (div == 0) ? 1 : div;
        return 3 + d * (OVERSAMPLE / 2 + OVERSAMPLE * (DATA_BITS + 1));
    endfunction

    function automatic int bad_gaps(input int gap);
        int bad;
        bad = 0;
        for (int i = 1; i < strobe_q.size(); i++)
            if (strobe_q[i] - strobe_q[i-1] != gap) bad++;
        return bad;
    endfunction

    task automatic clear_mon();
        strobe_q.delete();
        valid_q.delete();
        ferr_q.delete();
        data_q.delete();
        stray_ferr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_frame(input logic [DATA_BITS-1:0] d, input logic stop,
                               input int bp, input int tail);
        @(posedge clk_in);
        #1;
        fall_cyc   = cyc;
        bus.rx_in  = 1'b0;
        idle(bp);
        for (int i = 0; i < DATA_BITS; i++) begin
            bus.rx_in = d[i];
            idle(bp);
        end
        bus.rx_in = stop;
        idle(bp);
        idle(tail);
    endtask

    task automatic test_reset();
        bus.rx_in      = 1'b1;
        bus.div_factor = 32'd1;
        reset          = 1'b0;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        vectors++;
        if ({bus.busy, bus.bit_index, bus.rx_data, bus.rx_valid, bus.frame_error,
             bus.sample_strobe, bus.tick} !== '0)
            begin miscompares++; $display("FAIL reset_outputs: busy=%b idx=%0d data=%h valid=%b ferr=%b strobe=%b tick=%b, all required 0",
                bus.busy, bus.bit_index, bus.rx_data, bus.rx_valid, bus.frame_error, bus.sample_strobe, bus.tick); end
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        idle(3);
    endtask

    task automatic test_basic();
        int t0, lat;
        bus.div_factor = 32'd4;
        idle(4);
        t0 = n_tick;
        idle(40);
        vectors++;
        if (n_tick - t0 != 10) begin miscompares++; $display("FAIL basic_tick_rate: got %0d ticks in 40 cycles, expected 10", n_tick - t0); end
        clear_mon();
        drive_frame(8'hA5, 1'b1, 64, 40);
        vectors++;
        if (strobe_q.size() != DATA_BITS + 2) begin miscompares++; $display("FAIL basic_strobes: got %0d, expected %0d", strobe_q.size(), DATA_BITS + 2); end
        vectors++;
        if (bad_gaps(64) != 0) begin miscompares++; $display("FAIL basic_strobe_gap: %0d gaps differ from 64", bad_gaps(64)); end
        lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
        vectors++;
        if (valid_q.size() != 1 || lat < exp_lat(4) - 1 || lat > exp_lat(4) + 1)
            begin miscompares++; $display("FAIL basic_latency: valids=%0d latency=%0d, expected 1 valid at %0d+-1", valid_q.size(), lat, exp_lat(4)); end
        vectors++;
        if (data_q.size() != 1 || data_q[0] !== 8'hA5) begin miscompares++; $display("FAIL basic_data: got %h (n=%0d), expected a5", (data_q.size() > 0) ? data_q[0] : 8'hxx, data_q.size()); end
        vectors++;
        if (ferr_q.size() != 1 || ferr_q[0] !== 1'b0 || stray_ferr != 0) begin miscompares++; $display("FAIL basic_frame_error: got error asserted, expected 0"); end
        vectors++;
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_drop: got %b, expected 0", bus.busy); end
    endtask

    task automatic test_frame_error();
        logic [DATA_BITS-1:0] d;
        d = DATA_BITS'($urandom);
        bus.div_factor = 32'd4;
        idle(4);
        clear_mon();
        drive_frame(d, 1'b0, 64, 3 * 64);
        vectors++;
        if (valid_q.size() != 1 || ferr_q[0] !== 1'b1) begin miscompares++; $display("FAIL ferr_pulse: valids=%0d, expected 1 valid with frame_error=1", valid_q.size()); end
        vectors++;
        if (data_q.size() != 1 || data_q[0] !== d) begin miscompares++; $display("FAIL ferr_data: got %h, expected %h", (data_q.size() > 0) ? data_q[0] : 8'hxx, d); end
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ferr_wait_high_busy: got %b, expected 1", bus.busy); end
        bus.rx_in = 1'b1;
        idle(6);
        vectors++;
        if (bus.busy !== 1'b0 || valid_q.size() != 1 || stray_ferr != 0)
            begin miscompares++; $display("FAIL ferr_release: busy=%b valids=%0d, expected busy 0 and 1 valid", bus.busy, valid_q.size()); end
    endtask

    task automatic test_glitch();
        bus.div_factor = 32'd4;
        idle(4);
        clear_mon();
        bus.rx_in = 1'b0;
        idle(20);
        bus.rx_in = 1'b1;
        idle(80);
        vectors++;
        if (strobe_q.size() != 1 || valid_q.size() != 0 || bus.busy !== 1'b0)
            begin miscompares++; $display("FAIL glitch: strobes=%0d valids=%0d busy=%b, expected 1/0/0", strobe_q.size(), valid_q.size(), bus.busy); end
    endtask

    task automatic test_div_change();
        logic [DATA_BITS-1:0] d;
        int lat;
        d = DATA_BITS'($urandom);
        bus.div_factor = 32'd4;
        idle(4);
        clear_mon();
        fork
            drive_frame(d, 1'b1, 64, 20);
            begin
                idle(200);
                bus.div_factor = 32'd8;
            end
        join
        lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
        vectors++;
        if (valid_q.size() != 1 || lat < exp_lat(4) - 1 || lat > exp_lat(4) + 1 || bad_gaps(64) != 0)
            begin miscompares++; $display("FAIL divchg_old_rate: valids=%0d latency=%0d, expected 1 at %0d+-1", valid_q.size(), lat, exp_lat(4)); end
        vectors++;
        if (data_q.size() != 1 || data_q[0] !== d) begin miscompares++; $display("FAIL divchg_old_data: got %h, expected %h", (data_q.size() > 0) ? data_q[0] : 8'hxx, d); end
        idle(4);
        clear_mon();
        drive_frame(8'h3C, 1'b1, 128, 80);
        lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
        vectors++;
        if (valid_q.size() != 1 || lat < exp_lat(8) - 1 || lat > exp_lat(8) + 1 || bad_gaps(128) != 0)
            begin miscompares++; $display("FAIL divchg_new_rate: valids=%0d latency=%0d, expected 1 at %0d+-1", valid_q.size(), lat, exp_lat(8)); end
        vectors++;
        if (data_q.size() != 1 || data_q[0] !== 8'h3C) begin miscompares++; $display("FAIL divchg_new_data: got %h, expected 3c", (data_q.size() > 0) ? data_q[0] : 8'hxx); end
    endtask

    task automatic test_reset_mid_frame();
        logic [DATA_BITS-1:0] d;
        int lat;
        d = DATA_BITS'($urandom);
        bus.div_factor = 32'd4;
        idle(4);
        clear_mon();
        bus.rx_in = 1'b0;
        idle(64);
        for (int i = 0; i < 3; i++) begin
            bus.rx_in = d[i];
            idle(64);
        end
        bus.rx_in = d[3];
        idle(32);
        reset = 1'b0;
        @(posedge clk_in);
        #1;
        reset     = 1'b1;
        bus.rx_in = 1'b1;
        vectors++;
        if ({bus.busy, bus.bit_index, bus.rx_data, bus.rx_valid, bus.frame_error,
             bus.sample_strobe, bus.tick} !== '0)
            begin miscompares++; $display("FAIL midreset_outputs: busy=%b idx=%0d data=%h valid=%b ferr=%b strobe=%b tick=%b, all required 0",
                bus.busy, bus.bit_index, bus.rx_data, bus.rx_valid, bus.frame_error, bus.sample_strobe, bus.tick); end
        idle(100);
        vectors++;
        if (valid_q.size() != 0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_quiet: valids=%0d busy=%b, expected 0/0", valid_q.size(), bus.busy); end
        clear_mon();
        drive_frame(8'h5A, 1'b1, 64, 40);
        lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
        vectors++;
        if (data_q.size() != 1 || data_q[0] !== 8'h5A || lat < exp_lat(4) - 1 || lat > exp_lat(4) + 1)
            begin miscompares++; $display("FAIL midreset_next_frame: got %h latency %0d, expected 5a at %0d+-1", (data_q.size() > 0) ? data_q[0] : 8'hxx, lat, exp_lat(4)); end
    endtask

    task automatic test_div_zero_one();
        int t0, lat;
        for (int dv = 0; dv < 2; dv++) begin
            bus.div_factor = 32'(dv);
            idle(4);
            t0 = n_tick;
            idle(20);
            vectors++;
            if (n_tick - t0 != 20) begin miscompares++; $display("FAIL div%0d_tick_rate: got %0d ticks in 20 cycles, expected 20", dv, n_tick - t0); end
            clear_mon();
            drive_frame(8'hFF, 1'b1, 16, 20);
            lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
            vectors++;
            if (valid_q.size() != 1 || lat < exp_lat(dv) - 1 || lat > exp_lat(dv) + 1 || bad_gaps(16) != 0)
                begin miscompares++; $display("FAIL div%0d_timing: valids=%0d latency=%0d, expected 1 at %0d+-1", dv, valid_q.size(), lat, exp_lat(dv)); end
            vectors++;
            if (data_q.size() != 1 || data_q[0] !== 8'hFF) begin miscompares++; $display("FAIL div%0d_data: got %h, expected ff", dv, (data_q.size() > 0) ? data_q[0] : 8'hxx); end
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_BITS-1:0] d0, d1;
        int div;
        d0  = DATA_BITS'($urandom);
        d1  = DATA_BITS'($urandom);
        div = int'($urandom_range(2, 4));
        bus.div_factor = 32'(div);
        idle(4);
        clear_mon();
        drive_frame(d0, 1'b1, 16 * div, 0);
        drive_frame(d1, 1'b1, 16 * div, 40);
        vectors++;
        if (data_q.size() != 2 || data_q[0] !== d0 || data_q[1] !== d1)
            begin miscompares++; $display("FAIL back_to_back: got %0d bytes, expected %h then %h", data_q.size(), d0, d1); end
    endtask

    task automatic test_random();
        logic [DATA_BITS-1:0] d;
        int div, lat;
        for (int n = 0; n < 4; n++) begin
            d   = DATA_BITS'($urandom);
            div = int'($urandom_range(1, 5));
            bus.div_factor = 32'(div);
            idle(4);
            clear_mon();
            drive_frame(d, 1'b1, 16 * div, 30);
            lat = (valid_q.size() > 0) ? valid_q[0] - fall_cyc : -1;
            vectors++;
            if (data_q.size() != 1 || data_q[0] !== d || ferr_q[0] !== 1'b0)
                begin miscompares++; $display("FAIL random_data[%0d]: got %h, expected %h (div %0d)", n, (data_q.size() > 0) ? data_q[0] : 8'hxx, d, div); end
            vectors++;
            if (lat < exp_lat(div) - 1 || lat > exp_lat(div) + 1 || strobe_q.size() != DATA_BITS + 2)
                begin miscompares++; $display("FAIL random_timing[%0d]: latency %0d strobes %0d, expected %0d+-1 and %0d", n, lat, strobe_q.size(), exp_lat(div), DATA_BITS + 2); end
        end
    endtask

    initial begin
        bus.rx_in      = 1'b1;
        bus.div_factor = 32'd1;
        test_reset();
        test_basic();
        test_frame_error();
        test_glitch();
        test_div_change();
        test_reset_mid_frame();
        test_div_zero_one();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
